// File: rtl/column_move_fifo.sv
// column_move_fifo
// Receiving end of the per-column "send to move list" path. The eight cell
// units of one board column offer candidate moves. A round-robin arbiter
// accepts at most one move per cycle into a first-word-fall-through FIFO,
// and the FIFO presents moves one at a time to the move-list consumer.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   newboard_i     synchronous flush of FIFO and arbiter (board start pulse)
//   cell_valid_i   per-cell "move offered" flags, bit i = ypos i
//   cell_move_i    cell i move in bits [i*MW +: MW]
//   cell_ready_o   one-hot grant (or zero) accepting a cell's move this cycle
//   cell_done_i    per-cell done flags
//   mv_valid_o     FIFO head is valid
//   mv_data_o      FIFO head move
//   mv_ready_i     consumer takes the head this cycle
//   count_o        FIFO occupancy, 0..DEPTH
//   col_done_o     registered column-finished flag
module column_move_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int MW    = 15
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            newboard_i,
  input  logic [7:0]      cell_valid_i,
  input  logic [8*MW-1:0] cell_move_i,
  output logic [7:0]      cell_ready_o,
  input  logic [7:0]      cell_done_i,
  output logic            mv_valid_o,
  output logic [MW-1:0]   mv_data_o,
  input  logic            mv_ready_i,
  output logic [AW:0]     count_o,
  output logic            col_done_o
);

  logic [MW-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    rr_q, rr_d;
  logic          colDone_q, colDone_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [7:0]    grant;
  logic [2:0]    grantIdx;
  logic [2:0]    scanIdx;
  logic          found;
  logic [MW-1:0] selMove;

  // Round-robin arbiter: scan from the cell after the last one served,
  // wrapping 7 -> 0, and grant the first valid cell. Nothing is granted while
  // the FIFO is full or while a new board is starting, so a move is never
  // accepted and then dropped by the flush.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    scanIdx  = '0;
    found    = 1'b0;
    if (!full && !newboard_i) begin
      for (int k = 0; k < 8; k++) begin
        scanIdx = rr_q + 3'(k);
        if (!found && cell_valid_i[scanIdx]) begin
          found           = 1'b1;
          grant[scanIdx]  = 1'b1;
          grantIdx        = scanIdx;
        end
      end
    end
  end

  // Pick the granted cell's move word. Built as an AND-OR over the one-hot
  // grant so no variable part-select is needed.
  always_comb begin
    selMove = '0;
    for (int i = 0; i < 8; i++) begin
      if (grant[i]) begin
        selMove = cell_move_i[i*MW +: MW];
      end
    end
  end

  assign full         = (count_q == (AW+1)'(DEPTH));
  assign push         = |grant;
  assign pop          = mv_valid_o && mv_ready_i && !newboard_i;
  assign cell_ready_o = grant;
  assign mv_valid_o   = (count_q != '0);
  assign mv_data_o    = mem[rdPtr_q];
  assign count_o      = count_q;
  assign col_done_o   = colDone_q;

  // Next-state logic for pointers, occupancy, the arbiter pointer and the
  // column-done flag. A new board wins over any push or pop in the same
  // cycle. Pointers are AW bits wide, so they wrap at DEPTH on their own.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    rr_d      = rr_q;
    colDone_d = (&cell_done_i) && !(|cell_valid_i) && (count_q == '0) && !newboard_i;
    if (newboard_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      rr_d    = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + 1'b1;
        rr_d    = grantIdx + 3'd1;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers. Reset throws away everything buffered at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rr_q      <= '0;
      colDone_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
      colDone_q <= colDone_d;
    end
  end

  // Storage array. No reset: the count says which entries are meaningful,
  // and a push can never hit a full FIFO because the arbiter holds off.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wrPtr_q] <= selMove;
    end
  end

endmodule
